// File: rtl/memory_access_pkg.sv
// Shared encodings for the memory-stage data access unit.
package memory_access_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/memory_access_mem_align.sv
// Byte-lane steering for stores, load extension and access legality checks.
module mem_align
  import memory_access_pkg::*;
(
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      size,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            illegal
);
  logic [1:0]      lane;
  logic [XLEN-1:0] lane_data;

  always_comb begin
    lane      = addr[1:0];
    lane_data = rdata >> {lane, 3'b000};

    unique case (size)
      F3_B:    load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      F3_BU:   load_data = {24'd0, lane_data[7:0]};
      F3_H:    load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      F3_HU:   load_data = {16'd0, lane_data[15:0]};
      F3_W:    load_data = rdata;
      default: load_data = '0;
    endcase

    // Replicating the narrow datum lets the strobes alone pick the lane.
    unique case (size[1:0])
      2'b00:   wdata = {4{store_data[7:0]}};
      2'b01:   wdata = {2{store_data[15:0]}};
      default: wdata = store_data;
    endcase

    wstrb = 4'b0000;
    if (is_store) begin
      unique case (size)
        F3_B:    wstrb = 4'b0001 << lane;
        F3_H:    wstrb = 4'b0011 << lane;
        F3_W:    wstrb = 4'b1111;
        default: wstrb = 4'b0000;
      endcase
    end

    illegal = 1'b0;
    if (is_load)
      illegal = !(size inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else if (is_store)
      illegal = !(size inside {F3_B, F3_H, F3_W});

    misaligned = (is_load | is_store) &
                 (((size[1:0] == 2'b01) & addr[0]) |
                  ((size[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
  end
endmodule

// File: rtl/memory_access.sv
// Memory-stage data access FSM: issues req/gnt/rvalid bus transactions and
// presents the result to writeback through memory_ready_o / M_valM_o.
module memory_access #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            execute_vaild_i,
  input  logic            write_back_allow_in_i,
  input  logic            ED_mem_read_i,
  input  logic            ED_mem_write_i,
  input  logic [2:0]      ED_mem_size_i,
  input  logic [XLEN-1:0] ED_valE_i,
  input  logic [XLEN-1:0] ED_store_data_i,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic            dmem_err_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  output logic [XLEN-1:0] M_valM_o,
  output logic            memory_ready_o,
  output logic            memory_allow_in_o,
  output logic            mem_fault_o
);
  import memory_access_pkg::*;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state;
  logic [XLEN-1:0] data_q;
  logic            fault_q;
  logic [CW-1:0]   cnt;

  logic            is_load, is_store, acc, bad, go;
  logic            misaligned, illegal;
  logic [XLEN-1:0] load_data;

  assign is_load  = ED_mem_read_i;
  assign is_store = ED_mem_write_i & ~ED_mem_read_i;
  assign acc      = execute_vaild_i & (ED_mem_read_i | ED_mem_write_i);
  assign bad      = misaligned | illegal;
  // Gating with rst_n keeps the stage reporting ready while held in reset.
  assign go       = rst_n & acc & ~bad;

  mem_align u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .size       (ED_mem_size_i),
    .addr       (ED_valE_i),
    .store_data (ED_store_data_i),
    .rdata      (dmem_rdata_i),
    .wdata      (dmem_wdata_o),
    .wstrb      (dmem_wstrb_o),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      data_q  <= '0;
      fault_q <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (go) begin
          state <= dmem_gnt_i ? S_WAIT : S_REQ;
          cnt   <= '0;
        end
        S_REQ: if (dmem_gnt_i) begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            data_q  <= is_store ? '0 : load_data;
            fault_q <= dmem_err_i;
            state   <= S_DONE;
          end else if (TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1)) begin
            data_q  <= '0;
            fault_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: if (write_back_allow_in_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req_o        = rst_n & (((state == S_IDLE) & go) | (state == S_REQ));
  assign dmem_we_o         = dmem_req_o & is_store;
  assign dmem_addr_o       = {ED_valE_i[XLEN-1:2], 2'b00};
  assign memory_ready_o    = ((state == S_IDLE) & ~go) | (state == S_DONE);
  assign memory_allow_in_o = memory_ready_o & write_back_allow_in_i;
  assign M_valM_o          = (state == S_DONE) ? data_q : '0;
  assign mem_fault_o       = (state == S_DONE) ? fault_q
                           : ((state == S_IDLE) & rst_n & acc & bad);
endmodule
